// File: rtl/r_div_ctrl.sv
// Iterative radix-N integer divider: one combinational digit stage sequenced
// by an IDLE/BUSY/DONE controller, with signed handling by magnitude
// division followed by a registered sign fix.

// Combinational radix-N restoring step: retires K quotient bits per call.
module r_div_stage #(
    parameter int N_BITS  = 32,
    parameter int N_RADIX = 4,
    parameter int K       = $clog2(N_RADIX)
) (
    input  logic [N_BITS-1:0] r_i,
    input  logic [K-1:0]      n_i,
    input  logic [N_BITS-1:0] d_i,
    output logic [K-1:0]      q_o,
    output logic [N_BITS-1:0] r_o
);

    logic [N_BITS:0] acc_s;
    logic [K-1:0]    q_s;

    // Shift in one dividend bit at a time and subtract when the divisor fits.
    always_comb begin
        acc_s = {1'b0, r_i};
        q_s   = '0;
        for (int b = K - 1; b >= 0; b--) begin
            acc_s = {acc_s[N_BITS-1:0], n_i[b]};
            if (acc_s >= {1'b0, d_i}) begin
                acc_s  = acc_s - {1'b0, d_i};
                q_s[b] = 1'b1;
            end else begin
                q_s[b] = 1'b0;
            end
        end
        q_o = q_s;
        r_o = acc_s[N_BITS-1:0];
    end

endmodule

module r_div_ctrl #(
    parameter int N_BITS  = 32,
    parameter int N_RADIX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [N_BITS-1:0] dividend_i,
    input  logic [N_BITS-1:0] divisor_i,
    input  logic              signed_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [N_BITS-1:0] quotient_o,
    output logic [N_BITS-1:0] remainder_o,
    output logic              div_zero_o
);

    localparam int K     = $clog2(N_RADIX);
    localparam int ITER  = N_BITS / K;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;

    logic [CNT_W-1:0]  cnt_r;
    logic [N_BITS-1:0] rem_r;
    logic [N_BITS-1:0] quo_r;
    logic [N_BITS-1:0] shf_r;      // dividend magnitude, MSB-first digit feed (raw dividend on divide by zero)
    logic [N_BITS-1:0] dvs_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              zero_r;
    logic [N_BITS-1:0] quotient_r;
    logic [N_BITS-1:0] remainder_r;
    logic              div_zero_r;

    logic [K-1:0]      stage_q_s;
    logic [N_BITS-1:0] stage_r_s;
    logic [N_BITS-1:0] quo_nxt_s;
    logic              dvd_neg_s;
    logic              dvs_neg_s;

    function automatic logic [N_BITS-1:0] negate(input logic [N_BITS-1:0] v);
        return ~v + N_BITS'(1);
    endfunction

    r_div_stage #(
        .N_BITS  (N_BITS),
        .N_RADIX (N_RADIX),
        .K       (K)
    ) u_stage (
        .r_i (rem_r),
        .n_i (shf_r[N_BITS-1 -: K]),
        .d_i (dvs_r),
        .q_o (stage_q_s),
        .r_o (stage_r_s)
    );

    assign quo_nxt_s = (quo_r << K) | N_BITS'(stage_q_s);
    assign dvd_neg_s = signed_i & dividend_i[N_BITS-1];
    assign dvs_neg_s = signed_i & divisor_i[N_BITS-1];

    assign ready_o     = (state_r == ST_IDLE);
    assign valid_o     = (state_r == ST_DONE);
    assign quotient_o  = quotient_r;
    assign remainder_o = remainder_r;
    assign div_zero_o  = div_zero_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush overrides both handshakes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (valid_i) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (zero_r || (cnt_r == LAST_CNT)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (flush_i || ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and registered result with sign fix.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            shf_r       <= '0;
            dvs_r       <= '0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            zero_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i && !flush_i) begin
                        cnt_r   <= '0;
                        rem_r   <= '0;
                        quo_r   <= '0;
                        zero_r  <= (divisor_i == '0);
                        neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                        neg_r_r <= dvd_neg_s;
                        dvs_r   <= dvs_neg_s ? negate(divisor_i) : divisor_i;
                        if (divisor_i == '0) begin
                            shf_r <= dividend_i;
                        end else begin
                            shf_r <= dvd_neg_s ? negate(dividend_i) : dividend_i;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!flush_i) begin
                        if (zero_r) begin
                            quotient_r  <= '1;
                            remainder_r <= shf_r;
                            div_zero_r  <= 1'b1;
                        end else begin
                            rem_r <= stage_r_s;
                            quo_r <= quo_nxt_s;
                            shf_r <= shf_r << K;
                            cnt_r <= cnt_r + CNT_W'(1);
                            if (cnt_r == LAST_CNT) begin
                                quotient_r  <= neg_q_r ? negate(quo_nxt_s) : quo_nxt_s;
                                remainder_r <= neg_r_r ? negate(stage_r_s) : stage_r_s;
                                div_zero_r  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
